// File: rtl/macc_multichannel.sv
// rtl/macc_multichannel.sv - time-interleaved multichannel signed multiply-accumulate
//
// Purpose: NUM_CH independent signed accumulators sharing one pipelined
// multiplier. One sample per clock. A sample flagged IN_LAST closes its
// channel's frame, emits the sum on P with a one-cycle P_VALID strobe and
// clears that channel's accumulator and overflow flag.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset, wins over CE
//   CE         clock enable, 0 freezes every register
//   IN_VALID   sample valid
//   IN_LAST    last sample of the frame for channel CH
//   CH         channel index; indices >= NUM_CH are dropped
//   A, B       signed operands
//   ADDSUB     1 = acc + A*B, 0 = acc - A*B
//   LOAD       1 = use LOAD_DATA instead of the accumulator as the base
//   LOAD_DATA  signed preset
//   P          signed frame result, held between strobes
//   P_VALID    one CE-cycle result strobe
//   P_CH       channel of P
//   OVF        an overflow happened somewhere in the reported frame

module macc_multichannel #(
    parameter int WIDTH_A  = 25,
    parameter int WIDTH_B  = 18,
    parameter int WIDTH_P  = 48,
    parameter int NUM_CH   = 4,
    parameter int LATENCY  = 3,
    parameter int SATURATE = 0,
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               IN_VALID,
    input  logic               IN_LAST,
    input  logic [CW-1:0]      CH,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic               ADDSUB,
    input  logic               LOAD,
    input  logic [WIDTH_P-1:0] LOAD_DATA,
    output logic [WIDTH_P-1:0] P,
    output logic               P_VALID,
    output logic [CW-1:0]      P_CH,
    output logic               OVF
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int NS = 2 ** CW;
    // One bit per encodable channel index; set only for channels that exist.
    localparam logic [NS-1:0] CH_MASK = NS'((64'd1 << NUM_CH) - 64'd1);
    localparam logic [WIDTH_P-1:0] SAT_MAX = {1'b0, {(WIDTH_P-1){1'b1}}};
    localparam logic [WIDTH_P-1:0] SAT_MIN = {1'b1, {(WIDTH_P-1){1'b0}}};

    typedef struct packed {
        logic               valid;
        logic               last;
        logic               addsub;
        logic               load;
        logic [CW-1:0]      ch;
        logic [WIDTH_P-1:0] load_data;
    } ctrl_t;

    ctrl_t                      ctrl_q [LATENCY];
    ctrl_t                      ctrl_d [LATENCY];
    logic signed [WIDTH_A-1:0]  a_q, a_d;
    logic signed [WIDTH_B-1:0]  b_q, b_d;
    logic signed [PW-1:0]       prod_q [1:LATENCY-1];
    logic signed [PW-1:0]       prod_d [1:LATENCY-1];
    logic signed [WIDTH_P-1:0]  acc_q [NS];
    logic signed [WIDTH_P-1:0]  acc_d [NS];
    logic [NS-1:0]              ovf_q, ovf_d;
    logic [WIDTH_P-1:0]         p_q, p_d;
    logic                       p_valid_q, p_valid_d;
    logic [CW-1:0]              p_ch_q, p_ch_d;
    logic                       ovf_out_q, ovf_out_d;

    ctrl_t                      st;
    logic signed [WIDTH_P-1:0]  base;
    logic signed [WIDTH_P:0]    base_ext, prod_ext, sum_full;
    logic                       ovf_now;
    logic [WIDTH_P-1:0]         result;

    always_comb begin
        // Stage 0 captures the sample; out-of-range channels enter as bubbles.
        ctrl_d[0].valid     = IN_VALID && CH_MASK[CH];
        ctrl_d[0].last      = IN_LAST;
        ctrl_d[0].addsub    = ADDSUB;
        ctrl_d[0].load      = LOAD;
        ctrl_d[0].ch        = CH;
        ctrl_d[0].load_data = LOAD_DATA;
        a_d = A;
        b_d = B;
        for (int k = 1; k < LATENCY; k++) begin
            ctrl_d[k] = ctrl_q[k-1];
        end
        prod_d[1] = PW'(a_q) * PW'(b_q);
        for (int k = 2; k < LATENCY; k++) begin
            prod_d[k] = prod_q[k-1];
        end

        // Accumulate stage: read and write of acc[ch] happen in the same
        // cycle, so consecutive samples on one channel chain naturally.
        st       = ctrl_q[LATENCY-1];
        base     = st.load ? st.load_data : acc_q[st.ch];
        base_ext = {base[WIDTH_P-1], base};
        prod_ext = {{(WIDTH_P+1-PW){prod_q[LATENCY-1][PW-1]}}, prod_q[LATENCY-1]};
        sum_full = st.addsub ? (base_ext + prod_ext) : (base_ext - prod_ext);
        // The extra top bit disagrees with the sign bit only when the true
        // sum does not fit in WIDTH_P bits.
        ovf_now  = sum_full[WIDTH_P] ^ sum_full[WIDTH_P-1];
        if (ovf_now && (SATURATE != 0)) begin
            result = sum_full[WIDTH_P] ? SAT_MIN : SAT_MAX;
        end else begin
            result = sum_full[WIDTH_P-1:0];
        end

        acc_d     = acc_q;
        ovf_d     = ovf_q;
        p_d       = p_q;
        p_ch_d    = p_ch_q;
        ovf_out_d = ovf_out_q;
        p_valid_d = 1'b0;
        if (st.valid) begin
            if (st.last) begin
                p_d             = result;
                p_ch_d          = st.ch;
                ovf_out_d       = ovf_q[st.ch] | ovf_now;
                p_valid_d       = 1'b1;
                acc_d[st.ch]    = '0;
                ovf_d[st.ch]    = 1'b0;
            end else begin
                acc_d[st.ch]    = result;
                ovf_d[st.ch]    = ovf_q[st.ch] | ovf_now;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < LATENCY; k++) begin
                ctrl_q[k] <= '0;
            end
            for (int k = 1; k < LATENCY; k++) begin
                prod_q[k] <= '0;
            end
            for (int i = 0; i < NS; i++) begin
                acc_q[i] <= '0;
            end
            a_q       <= '0;
            b_q       <= '0;
            ovf_q     <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            p_ch_q    <= '0;
            ovf_out_q <= 1'b0;
        end else if (CE) begin
            ctrl_q    <= ctrl_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ovf_q     <= ovf_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            p_ch_q    <= p_ch_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign P       = p_q;
    assign P_VALID = p_valid_q;
    assign P_CH    = p_ch_q;
    assign OVF     = ovf_out_q;

endmodule

// File: tb/tb_macc_multichannel.sv
// tb/tb_macc_multichannel.sv - self-checking bench for macc_multichannel

module tb_macc_multichannel;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst, ce, in_valid, in_valid_w, in_last, addsub, load;
    logic [1:0]  ch;
    logic [24:0] a;
    logic [17:0] b;
    logic [47:0] ld;

    logic [47:0] p_m;
    logic        pv_m, ovf_m;
    logic [1:0]  pch_m;
    logic [43:0] p_s, p_w;
    logic        pv_s, ovf_s, pv_w, ovf_w;
    logic [1:0]  pch_s, pch_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [1:0]  ch;
        logic [47:0] p;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [1:0]  ch;
        int          a;
        int          b;
        logic        addsub;
        logic        load;
        logic [47:0] ld;
        logic        last;
        logic [47:0] exp_p;
        logic        exp_ovf;
    } vec_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_w[$];
    vec_t tbl[$];
    longint acc_m[4];

    macc_multichannel u_main (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
        .CH(ch), .A(a), .B(b), .ADDSUB(addsub), .LOAD(load), .LOAD_DATA(ld),
        .P(p_m), .P_VALID(pv_m), .P_CH(pch_m), .OVF(ovf_m)
    );

    macc_multichannel #(.WIDTH_P(44), .NUM_CH(3), .SATURATE(1)) u_sat (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid_w), .IN_LAST(in_last),
        .CH(ch), .A(a), .B(b), .ADDSUB(addsub), .LOAD(load), .LOAD_DATA(ld[43:0]),
        .P(p_s), .P_VALID(pv_s), .P_CH(pch_s), .OVF(ovf_s)
    );

    macc_multichannel #(.WIDTH_P(44), .NUM_CH(3), .SATURATE(0)) u_wrap (
        .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid_w), .IN_LAST(in_last),
        .CH(ch), .A(a), .B(b), .ADDSUB(addsub), .LOAD(load), .LOAD_DATA(ld[43:0]),
        .P(p_w), .P_VALID(pv_w), .P_CH(pch_w), .OVF(ovf_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ce) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Strobes are consumed at the next edge only when CE is high.
    always @(negedge clk) begin
        exp_t e;
        if (pv_m && ce) begin
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL main_unexpected ch=%0d p=%h", pch_m, p_m);
            end else begin
                e = q_m.pop_front();
                chk("main_p", p_m, e.p);
                chk("main_ch", 48'(pch_m), 48'(e.ch));
                chk("main_ovf", 48'(ovf_m), 48'(e.ovf));
                chk("main_due", 48'(cyc), 48'(e.due));
            end
        end
        if (pv_s && ce) begin
            if (q_s.size() == 0) begin
                total++; bad++;
                $display("FAIL sat_unexpected ch=%0d p=%h", pch_s, p_s);
            end else begin
                e = q_s.pop_front();
                chk("sat_p", {{4{p_s[43]}}, p_s}, e.p);
                chk("sat_ch", 48'(pch_s), 48'(e.ch));
                chk("sat_ovf", 48'(ovf_s), 48'(e.ovf));
            end
        end
        if (pv_w && ce) begin
            if (q_w.size() == 0) begin
                total++; bad++;
                $display("FAIL wrap_unexpected ch=%0d p=%h", pch_w, p_w);
            end else begin
                e = q_w.pop_front();
                chk("wrap_p", {{4{p_w[43]}}, p_w}, e.p);
                chk("wrap_ch", 48'(pch_w), 48'(e.ch));
                chk("wrap_ovf", 48'(ovf_w), 48'(e.ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] c, input int av, input int bv, input logic as,
                       input logic lo, input logic [47:0] ldv, input logic lst);
        ch = c; a = av[24:0]; b = bv[17:0];
        addsub = as; load = lo; ld = ldv; in_last = lst;
    endtask

    // sel: 0 = main, 1 = saturating 44-bit, 2 = wrapping 44-bit
    task automatic push(input int sel, input logic [1:0] c, input logic [47:0] pv, input logic o);
        exp_t e;
        e.due = cyc + 1 + LAT; e.ch = c; e.p = pv; e.ovf = o;
        if (sel == 0) q_m.push_back(e);
        else if (sel == 1) q_s.push_back(e);
        else q_w.push_back(e);
    endtask

    task automatic add_vec(input logic [1:0] c, input int av, input int bv, input logic as,
                           input logic lo, input logic [47:0] ldv, input logic lst,
                           input logic [47:0] ep, input logic eo);
        vec_t v;
        v.ch = c; v.a = av; v.b = bv; v.addsub = as; v.load = lo; v.ld = ldv;
        v.last = lst; v.exp_p = ep; v.exp_ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q_m.size() + q_s.size() + q_w.size()) != 0; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        longint v, base, pr;
        int av, bv, ldv;
        logic as, lo, lst;
        logic [1:0] c;

        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; in_valid_w = 1'b0;
        put(2'd0, 0, 0, 1'b1, 1'b0, 48'd0, 1'b0);

        // Reset must act even while CE is low.
        repeat (3) step();
        chk("rst_p", p_m, 48'd0);
        chk("rst_pv", 48'(pv_m), 48'd0);
        chk("rst_pch", 48'(pch_m), 48'd0);
        chk("rst_ovf", 48'(ovf_m), 48'd0);
        ce = 1'b1;
        step();
        rst = 1'b0;
        step();

        add_vec(2'd0,  3,  4, 1'b1, 1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
        add_vec(2'd0,  5, -2, 1'b1, 1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
        add_vec(2'd0, -7,  1, 1'b1, 1'b0, 48'd0, 1'b1, -5, 1'b0);
        add_vec(2'd0,  2,  2, 1'b1, 1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
        add_vec(2'd1,  1, -1, 1'b0, 1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
        add_vec(2'd0,  2,  2, 1'b1, 1'b0, 48'd0, 1'b0, 48'd0, 1'b0);
        add_vec(2'd1,  1, -1, 1'b0, 1'b0, 48'd0, 1'b1, 48'd2, 1'b0);
        add_vec(2'd0,  2,  2, 1'b1, 1'b0, 48'd0, 1'b1, 48'd12, 1'b0);
        add_vec(2'd2, 10, 10, 1'b1, 1'b1, 48'd1000, 1'b0, 48'd0, 1'b0);
        add_vec(2'd2,  1,  1, 1'b1, 1'b0, 48'd0, 1'b1, 48'd1101, 1'b0);
        add_vec(2'd2,  2,  3, 1'b1, 1'b0, 48'd0, 1'b1, 48'd6, 1'b0);
        add_vec(2'd3,  1,  1, 1'b1, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 48'h8000_0000_0000, 1'b1);
        add_vec(2'd3,  1,  1, 1'b0, 1'b1, 48'h8000_0000_0000, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1);
        add_vec(2'd3,  1,  1, 1'b1, 1'b0, 48'd0, 1'b1, 48'd1, 1'b0);
        add_vec(2'd1,  0,  9, 1'b1, 1'b1, -5, 1'b1, -5, 1'b0);

        foreach (tbl[i]) begin
            put(tbl[i].ch, tbl[i].a, tbl[i].b, tbl[i].addsub, tbl[i].load, tbl[i].ld, tbl[i].last);
            in_valid = 1'b1;
            if (tbl[i].last) push(0, tbl[i].ch, tbl[i].exp_p, tbl[i].exp_ovf);
            step();
        end
        in_valid = 1'b0;
        drain();

        // 44-bit instances: 2^41 five times overflows on the fourth add.
        for (int k = 0; k < 5; k++) begin
            put(2'd0, -(1 << 24), -(1 << 17), 1'b1, 1'b0, 48'd0, k == 4);
            in_valid_w = 1'b1;
            if (k == 4) begin
                v = (longint'(1) << 43) - 1;
                push(1, 2'd0, v[47:0], 1'b1);
                v = -3 * (longint'(1) << 41);
                push(2, 2'd0, v[47:0], 1'b1);
            end
            step();
        end
        // Channel 3 does not exist on these instances and must vanish.
        put(2'd3, 1, 1, 1'b1, 1'b0, 48'd0, 1'b1);
        step();
        put(2'd0, 1, 1, 1'b1, 1'b0, 48'd0, 1'b1);
        push(1, 2'd0, 48'd1, 1'b0);
        push(2, 2'd0, 48'd1, 1'b0);
        step();
        in_valid_w = 1'b0;
        drain();

        // Random interleaved traffic against a behavioural model.
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end else begin
                c   = 2'($urandom_range(0, 3));
                av  = int'($urandom_range(0, 200)) - 100;
                bv  = int'($urandom_range(0, 200)) - 100;
                as  = 1'($urandom_range(0, 1));
                lo  = ($urandom_range(0, 7) == 0);
                lst = ($urandom_range(0, 3) == 0);
                ldv = int'($urandom_range(0, 2000)) - 1000;
                base = lo ? longint'(ldv) : acc_m[c];
                pr   = longint'(av) * longint'(bv);
                v    = as ? base + pr : base - pr;
                put(c, av, bv, as, lo, ldv, lst);
                in_valid = 1'b1;
                if (lst) begin
                    push(0, c, v[47:0], 1'b0);
                    acc_m[c] = 0;
                end else begin
                    acc_m[c] = v;
                end
                step();
            end
        end
        for (int i = 0; i < 4; i++) begin
            v = acc_m[i];
            put(2'(i), 0, 0, 1'b1, 1'b0, 48'd0, 1'b1);
            in_valid = 1'b1;
            push(0, 2'(i), v[47:0], 1'b0);
            step();
        end
        in_valid = 1'b0;
        drain();

        // Stall while the sample is inside the pipeline.
        put(2'd0, 3, 4, 1'b1, 1'b0, 48'd0, 1'b1);
        in_valid = 1'b1;
        push(0, 2'd0, 48'd12, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        ce = 1'b0;
        repeat (5) step();
        ce = 1'b1;
        drain();

        // Stall on the strobe cycle itself.
        put(2'd2, 7, -3, 1'b1, 1'b0, 48'd0, 1'b1);
        in_valid = 1'b1;
        push(0, 2'd2, -21, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_pv", 48'(pv_m), 48'd1);
            chk("stall_p", p_m, -21);
        end
        ce = 1'b1;
        step();
        chk("stall_pv_drop", 48'(pv_m), 48'd0);
        chk("stall_p_hold", p_m, -21);
        chk("stall_q_empty", 48'(q_m.size()), 48'd0);

        // Reset with a partial sum stored and two samples in flight.
        put(2'd1, 5, 5, 1'b1, 1'b0, 48'd0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        put(2'd1, 1, 1, 1'b1, 1'b0, 48'd0, 1'b0);
        in_valid = 1'b1;
        step();
        put(2'd1, 1, 1, 1'b1, 1'b0, 48'd0, 1'b1);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_mid_pv", 48'(pv_m), 48'd0);
        end
        chk("rst_mid_p", p_m, 48'd0);
        chk("rst_mid_pch", 48'(pch_m), 48'd0);
        put(2'd1, 2, 2, 1'b1, 1'b0, 48'd0, 1'b1);
        in_valid = 1'b1;
        push(0, 2'd1, 48'd4, 1'b0);
        step();
        in_valid = 1'b0;
        drain();

        chk("end_q_main", 48'(q_m.size()), 48'd0);
        chk("end_q_sat", 48'(q_s.size()), 48'd0);
        chk("end_q_wrap", 48'(q_w.size()), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macc_multichannel.md
Name: macc_multichannel

Overview:
- Parametrised, pipelined signed multiply-accumulate engine for the DSP datapath.
- Keeps NUM_CH independent accumulators, time-interleaved on one shared multiplier, and accepts one sample per clock.
- A sample marked last closes the frame for its channel and emits that channel's result with a valid strobe.
- Adds per-sample add/subtract, load-preset, optional saturation and per-frame overflow flagging.

Parameters:
- WIDTH_A, 25, signed multiplier A width, 2-25.
- WIDTH_B, 18, signed multiplier B width, 2-18.
- WIDTH_P, 48, accumulator/output width; must be >= WIDTH_A+WIDTH_B, <= 48.
- NUM_CH, 4, number of independent accumulators, 1-16.
- LATENCY, 3, cycles from accepted sample to its registered accumulate result, 2-4.
- SATURATE, 0, 0 = two's-complement wrap, 1 = clamp to signed WIDTH_P range.

Ports:
- CLK  in  1  positive-edge clock.
- RST  in  1  synchronous active-high reset.
- CE  in  1  active-high clock enable; 0 freezes every register.
- IN_VALID  in  1  sample valid.
- IN_LAST  in  1  last sample of the frame for channel CH.
- CH  in  max(1,clog2(NUM_CH))  channel index of the sample.
- A  in  WIDTH_A  signed multiplicand.
- B  in  WIDTH_B  signed multiplier.
- ADDSUB  in  1  1 = acc + A*B, 0 = acc - A*B.
- LOAD  in  1  1 = seed the accumulator: acc = LOAD_DATA ± A*B.
- LOAD_DATA  in  WIDTH_P  signed preset value.
- P  out  WIDTH_P  signed frame result.
- P_VALID  out  1  single-cycle result strobe.
- P_CH  out  max(1,clog2(NUM_CH))  channel of P.
- OVF  out  1  overflow occurred in the reported frame.

Behaviour:
- Reset (RST=1 at a CLK edge while CE=1, or regardless of CE): all pipeline valids 0, all accumulators 0, per-channel overflow flags 0, P=0, P_VALID=0, P_CH=0, OVF=0. RST has priority over CE.
- Reset mid-frame discards in-flight samples; no P_VALID is produced for them.
- A sample is accepted when CE=1 and IN_VALID=1. There is no backpressure.
- CH >= NUM_CH: the sample is dropped, with no accumulator or flag update.
- Pipeline:
  - Stages 1..LATENCY-1 register the operands and the product, and carry the controls (CH, LAST, ADDSUB, LOAD, LOAD_DATA).
  - Stage LATENCY reads acc[CH], adds or subtracts the sign-extended product (or uses LOAD_DATA as the base), and writes acc[CH].
  - Read and write happen in the same stage, so back-to-back samples on the same channel need no stall or forwarding.
- Result timing:
  - A last sample accepted at edge n gives P_VALID=1 at edge n+LATENCY (CE counted cycles).
  - P is the final sum, P_CH the channel, and OVF is the OR of that frame's overflow events.
  - In the same cycle acc[CH] and ovf[CH] are cleared, so the next frame starts from 0 unless LOAD is set.
- P_VALID is 1 for exactly one CE cycle per last sample. P, P_CH and OVF hold between strobes.
- Overflow: the full-precision sum is computed in WIDTH_P+1 bits. Overflow means it lies outside [-2^(WIDTH_P-1), 2^(WIDTH_P-1)-1].
  - SATURATE=0: the result wraps and ovf[CH] is set.
  - SATURATE=1: the result clamps to the nearest bound and ovf[CH] is set.
- LOAD with IN_LAST on one sample: P = LOAD_DATA ± A*B, emitted at once.
- CE=0: every stage, accumulator and output holds. A pending P_VALID=1 stays asserted until CE returns, then drops after one enabled cycle.
- Channels are independent; samples for different channels may be interleaved in any order.

Test Plan:
- WIDTH defaults, LATENCY=3, CH=0: samples (3,4),(5,-2),(−7,1) with ADDSUB=1, last on the third -> P_VALID at 3 cycles after the last sample, P=-5, P_CH=0, OVF=0.
- Interleave CH0 (2,2)x3 and CH1 (1,-1)x2 with ADDSUB=0 on CH1, last on each final sample -> CH0 reports P=12, CH1 reports P=2, each on its own single-cycle strobe in input order.
- LOAD=1, LOAD_DATA=1000, (10,10), then (1,1) with last -> P=1101. The following frame (2,3) with last -> P=6, confirming the clear.
- WIDTH_P=44 (min width WIDTH_A+WIDTH_B=43): accumulate (-2^24,-2^17) five times.
  - SATURATE=1 -> P=2^43-1, OVF=1.
  - SATURATE=0 -> wrapped value, OVF=1.
  - The next frame shows OVF=0.
- CE=0 held 5 cycles mid-pipeline and on a P_VALID cycle -> outputs frozen, P_VALID asserted through the stall. Results match the unstalled run with cycle shift only.
- RST asserted for 1 cycle with 2 samples in flight (one last) -> no P_VALID afterwards, P=0, and a subsequent frame sums from 0.
